rng_harvester: RTL

Digitises the free-running ring-oscillator output into packed random words. Sits directly downstream of the ring oscillator. Drives the oscillator enable, synchronises and periodically samples its asynchronous output, and optionally applies von Neumann debiasing. Delivers WIDTH-bit words over a valid/ready handshake, with a sticky repetition-count health check.

---
 rtl/rng_harvester.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rng_harvester.sv
// Ring-oscillator harvester: sync + periodic sampling, optional von Neumann debias (RNG_VN_DEBIAS_EN), rep-count health.
// Latency: raw build emits a word WARMUP + WIDTH*SAMPLE_DIV cycles after en; debiased build is variable.
// Backpressure: word held in HOLD with sampling paused until rdy_i; health failure is sticky until res_n.
module rng_harvester #(
   parameter int WIDTH      = 8,
   parameter int SAMPLE_DIV = 4,
   parameter int WARMUP     = 16,
   parameter int REP_LIMIT  = 32
) (
   input  logic             clk,
   input  logic             res_n,
   input  logic             en,
   input  logic             ro_q,
   output logic             ro_en,
   input  logic             rdy_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             fail_o
);

   localparam int DIV_W  = $clog2(SAMPLE_DIV);
   localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int BIT_W  = $clog2(WIDTH);
   localparam int REP_W  = $clog2(REP_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WARMUP,
      S_COLLECT,
      S_HOLD,
      S_FAIL
   } state_t;

   state_t            state;
   logic [1:0]        sync_q;
   logic [WARM_W-1:0] warm_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [REP_W-1:0]  rep_cnt;
   logic              last_raw;
   logic [WIDTH-2:0]  shreg;

   logic              raw;
   logic              tick;
   logic [REP_W-1:0]  rep_next;
   logic              trip;
   logic              bit_vld;
   logic              bit_val;
   logic              word_done;
   logic [WIDTH-1:0]  word_nxt;

   assign raw = sync_q[1];

`ifdef RNG_VN_DEBIAS_EN
   logic pair_flag;
   logic pair_a;

   // Pair flag is forced clear outside COLLECT, so every entry to COLLECT starts a fresh pair.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         pair_flag <= 1'b0;
         pair_a    <= 1'b0;
      end else if (state != S_COLLECT) begin
         pair_flag <= 1'b0;
      end else if (tick) begin
         pair_flag <= ~pair_flag;
         pair_a    <= raw;
      end
   end
`endif

   always_comb begin
      tick      = (state == S_COLLECT) && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
      rep_next  = ((rep_cnt == '0) || (raw != last_raw)) ? REP_W'(1) : rep_cnt + REP_W'(1);
      trip      = tick && (rep_next == REP_W'(REP_LIMIT));
`ifdef RNG_VN_DEBIAS_EN
      bit_vld   = tick && pair_flag && (pair_a != raw);
      bit_val   = pair_a;
`else
      bit_vld   = tick;
      bit_val   = raw;
`endif
      word_done = bit_vld && (bit_cnt == BIT_W'(WIDTH - 1));
      word_nxt  = {shreg, bit_val};
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state    <= S_IDLE;
         sync_q   <= 2'b00;
         warm_cnt <= '0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         rep_cnt  <= '0;
         last_raw <= 1'b0;
         shreg    <= '0;
         ro_en    <= 1'b0;
         data_o   <= '0;
         valid_o  <= 1'b0;
         fail_o   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], ro_q};
         case (state)
            S_IDLE: begin
               ro_en    <= 1'b0;
               warm_cnt <= '0;
               div_cnt  <= '0;
               bit_cnt  <= '0;
               rep_cnt  <= '0;
               shreg    <= '0;
               if (en) begin
                  state <= S_WARMUP;
                  ro_en <= 1'b1;
               end
            end
            S_WARMUP: begin
               if (!en) begin
                  state    <= S_IDLE;
                  ro_en    <= 1'b0;
                  warm_cnt <= '0;
               end else if (warm_cnt == WARM_W'(WARMUP - 1)) begin
                  state    <= S_COLLECT;
                  warm_cnt <= '0;
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  rep_cnt  <= '0;
               end else begin
                  warm_cnt <= warm_cnt + WARM_W'(1);
               end
            end
            S_COLLECT: begin
               if (trip) begin
                  // Health trip outranks a word completing on the same tick.
                  state   <= S_FAIL;
                  fail_o  <= 1'b1;
                  ro_en   <= 1'b0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
               end else if (!en) begin
                  state   <= S_IDLE;
                  ro_en   <= 1'b0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  rep_cnt <= '0;
               end else begin
                  div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                  if (tick) begin
                     last_raw <= raw;
                     rep_cnt  <= rep_next;
                  end
                  if (bit_vld) begin
                     shreg <= word_nxt[WIDTH-2:0];
                     if (word_done) begin
                        data_o  <= word_nxt;
                        valid_o <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_HOLD;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end
                  end
               end
            end
            S_HOLD: begin
               // rep_cnt survives the hold so the health check sees one continuous stream.
               if (rdy_i) begin
                  valid_o <= 1'b0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  if (en) begin
                     state <= S_COLLECT;
                  end else begin
                     state <= S_IDLE;
                     ro_en <= 1'b0;
                  end
               end
            end
            S_FAIL: begin
               ro_en   <= 1'b0;
               valid_o <= 1'b0;
               fail_o  <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               ro_en <= 1'b0;
            end
         endcase
      end
   end

endmodule
